// File: rtl/debug_word_fmt.sv
// debug_word_fmt
//   Turns one debug word (5-bit register tag plus 32-bit value) into the ASCII
//   text "rNN=HHHHHHHH" followed by a separator. The separator is a space, or
//   an end of line when in_last is set. The text is handed to uart_buffer one
//   character per strobe, and the block honours uart_buffer back-pressure.
//
// Parameters
//   PREFIX     first character of every word (default 'r')
//   UPPER_HEX  1: hex letters A-F, 0: a-f
//   EOL_CRLF   end of line when in_last: 1 -> CR LF, 0 -> LF only
//
// Ports
//   clk         in   system clock
//   rstn        in   asynchronous active-low reset
//   in_valid    in   word request
//   in_ready    out  idle; a word is accepted when in_valid & in_ready
//   in_tag      in   register index, printed as two decimal digits
//   in_data     in   value, printed as eight hex digits, MSB nibble first
//   in_last     in   terminate the line with end of line instead of a space
//   uart_busy   in   uart_buffer cannot take a character this cycle
//   char_valid  out  one-cycle strobe qualifying char
//   char        out  ASCII character
module debug_word_fmt #(
  parameter logic [7:0] PREFIX    = 8'h72,
  parameter bit         UPPER_HEX = 1'b1,
  parameter bit         EOL_CRLF  = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_tag,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        uart_busy,
  output logic        char_valid,
  output logic [7:0]  char
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [4:0]  r_tag;
  logic [31:0] r_data;
  logic        r_last;
  logic        r_cv;
  logic [7:0]  r_char;

  logic [1:0]  w_tens;
  logic [4:0]  w_tens_x10;
  logic [3:0]  w_ones;
  logic [3:0]  w_len;
  logic [3:0]  w_last_idx;
  logic [7:0]  w_seq;

  // Decimal tens digit of a 0..31 tag; a compare chain is cheaper than a divider.
  function automatic logic [1:0] tens_of(input logic [4:0] t);
    if (t >= 5'd30)      return 2'd3;
    else if (t >= 5'd20) return 2'd2;
    else if (t >= 5'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign w_tens     = tens_of(r_tag);
  assign w_tens_x10 = {3'b000, w_tens} * 5'd10;
  assign w_ones     = 4'(r_tag - w_tens_x10);

  // CR LF adds one character to the final separator.
  assign w_len      = (r_last && EOL_CRLF) ? 4'd14 : 4'd13;
  assign w_last_idx = w_len - 4'd1;

  // Character selected by the current sequence position.
  always_comb begin
    w_seq = 8'h00;
    case (r_idx)
      4'd0:    w_seq = PREFIX;
      4'd1:    w_seq = 8'h30 + {6'b000000, w_tens};
      4'd2:    w_seq = 8'h30 + {4'h0, w_ones};
      4'd3:    w_seq = 8'h3D;
      4'd4:    w_seq = hex_ascii(r_data[31:28]);
      4'd5:    w_seq = hex_ascii(r_data[27:24]);
      4'd6:    w_seq = hex_ascii(r_data[23:20]);
      4'd7:    w_seq = hex_ascii(r_data[19:16]);
      4'd8:    w_seq = hex_ascii(r_data[15:12]);
      4'd9:    w_seq = hex_ascii(r_data[11:8]);
      4'd10:   w_seq = hex_ascii(r_data[7:4]);
      4'd11:   w_seq = hex_ascii(r_data[3:0]);
      4'd12:   w_seq = !r_last ? 8'h20 : (EOL_CRLF ? 8'h0D : 8'h0A);
      4'd13:   w_seq = 8'h0A;
      default: w_seq = 8'h00;
    endcase
  end

  assign in_ready   = (r_state == IDLE);
  assign char_valid = r_cv;
  assign char       = r_char;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_tag   <= 5'd0;
      r_data  <= 32'd0;
      r_last  <= 1'b0;
      r_cv    <= 1'b0;
      r_char  <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          r_cv <= 1'b0;
          if (in_valid) begin
            r_tag   <= in_tag;
            r_data  <= in_data;
            r_last  <= in_last;
            r_idx   <= 4'd0;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          // A strobe is always followed by a gap cycle, so uart_busy raised in
          // response to a character is seen before the next one goes out.
          if (!uart_busy && !r_cv) begin
            r_cv   <= 1'b1;
            r_char <= w_seq;
            r_idx  <= (r_idx == w_len) ? r_idx : r_idx + 4'd1;
            // Going idle on the final character lets the next word be
            // accepted while that character is still being strobed.
            if (r_idx == w_last_idx) r_state <= IDLE;
          end else begin
            r_cv <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
